spi_byte_feeder: RTL and testbench

//  Byte buffer and pacer directly upstream of the PL-side SPI mode-0 byte sender.

---
 rtl/spi_feed_pkg.sv | 9 +
 rtl/spi_byte_feeder_if.sv | 22 ++
 rtl/spi_feed_fifo.sv | 37 +++
 rtl/spi_byte_feeder.sv | 126 ++++++++++++
 tb/tb_spi_byte_feeder.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_feed_pkg.sv
// spi_feed_pkg: shared FSM encoding, sender timing limits and sizing helper for spi_byte_feeder
package spi_feed_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, PULSE, GAP} feed_state_t;
    localparam int SPI_BYTE_CYCLES = 18;
    localparam int MIN_BYTE_GAP = 20;
    function automatic int cnt_width(input int a, input int b);
        return $clog2(a > b ? a : b) + 1;
    endfunction
endpackage

// File: rtl/spi_byte_feeder_if.sv
// spi_byte_feeder_if: upstream byte stream plus paced strobe/status towards the SPI sender
interface spi_byte_feeder_if #(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 16
);
    logic in_valid;
    logic [DATA_W-1:0] in_data;
    logic in_last;
    logic in_ready;
    logic tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, tx_valid, tx_data, busy, fifo_level
    );
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, tx_valid, tx_data, busy, fifo_level
    );
endinterface

// File: rtl/spi_feed_fifo.sv
// spi_feed_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers
module spi_feed_fifo #(
    parameter int W = 9,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  logic [W-1:0] wdata,
    input  logic rd_en,
    output logic [W-1:0] rdata,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign level = wr_ptr - rd_ptr;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign rdata = mem[rd_ptr[AW-1:0]];
    // pointer advance; the extra top bit tells full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/spi_byte_feeder.sv
// spi_byte_feeder: buffers a byte stream and paces it to the SPI sender; SPI_FEED_HDR_EN adds a sync header per frame
module spi_byte_feeder
    import spi_feed_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int VALID_HI = 2,
    parameter int BYTE_GAP = 24,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
    input logic clk,
    input logic rst_n,
    spi_byte_feeder_if.slave bus
);
    localparam int CW = cnt_width(VALID_HI, BYTE_GAP);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if (DATA_W != 8) begin : g_bad_width
        $error("DATA_W must be 8, got %0d", DATA_W);
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2, got %0d", FIFO_DEPTH);
    end
    if (VALID_HI < 1) begin : g_bad_hi
        $error("VALID_HI must be >= 1, got %0d", VALID_HI);
    end
    if (BYTE_GAP < MIN_BYTE_GAP) begin : g_bad_gap
        $error("BYTE_GAP must be >= %0d, got %0d", MIN_BYTE_GAP, BYTE_GAP);
    end
    if (VALID_HI + BYTE_GAP + 1 < SPI_BYTE_CYCLES) begin : g_bad_period
        $error("byte period shorter than the sender needs");
    end

    feed_state_t state;
    logic [CW-1:0] cnt;
    logic rdy;
    logic full, empty, push, pop;
    logic [LW-1:0] level;
    logic [DATA_W:0] rdata;
    logic [DATA_W-1:0] load_data;
    logic tx_valid_q;
    logic [DATA_W-1:0] tx_data_q;

    assign push = bus.in_valid && bus.in_ready;
    assign bus.in_ready = rdy && !full;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data = tx_data_q;
    assign bus.busy = state != IDLE || !empty;
    assign bus.fifo_level = level;

    spi_feed_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(push),
        .wdata({bus.in_last, bus.in_data}),
        .rd_en(pop),
        .rdata(rdata),
        .full(full),
        .empty(empty),
        .level(level)
    );

    // in_ready stays low while reset is held and rises on the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy <= 1'b0;
        else rdy <= 1'b1;
    end

`ifdef SPI_FEED_HDR_EN
    logic frame_start, last_q;
    assign pop = state == LOAD && !frame_start;
    assign load_data = frame_start ? SYNC_BYTE : rdata[DATA_W-1:0];
    // a header slot is owed at reset and after the pulse of a frame's last byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b1;
            last_q <= 1'b0;
        end else if (state == LOAD) begin
            frame_start <= 1'b0;
            last_q <= !frame_start && rdata[DATA_W];
        end else if (state == PULSE && cnt == '0 && last_q) begin
            frame_start <= 1'b1;
        end
    end
`else
    logic unused_last;
    logic [DATA_W-1:0] unused_sync;
    assign unused_last = rdata[DATA_W];
    assign unused_sync = SYNC_BYTE;
    assign pop = state == LOAD;
    assign load_data = rdata[DATA_W-1:0];
`endif

    // pacing FSM: load a byte, strobe it for VALID_HI cycles, then hold the line idle for BYTE_GAP cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) state <= LOAD;
                LOAD: begin
                    tx_data_q <= load_data;
                    tx_valid_q <= 1'b1;
                    cnt <= CW'(VALID_HI - 1);
                    state <= PULSE;
                end
                PULSE: begin
                    if (cnt == '0) begin
                        tx_valid_q <= 1'b0;
                        cnt <= CW'(BYTE_GAP - 1);
                        state <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (cnt == '0) state <= empty ? IDLE : LOAD;
                    else cnt <= cnt - 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_feeder.sv
// tb_spi_byte_feeder: table, directed and random checks of spi_byte_feeder against a timing-formula scoreboard
module tb_spi_byte_feeder;
    localparam int VH = 2;
    localparam int BG = 24;
    localparam int PER = VH + BG + 1;
    localparam int DEPTH = 16;
`ifdef SPI_FEED_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    typedef struct {
        int cyc;
        logic [7:0] d;
    } em_t;
    typedef struct {
        logic [7:0] d;
        bit l;
        int idle;
        logic [7:0] exp_first;
        int exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int wid_bad = 0, gap_bad = 0, dat_bad = 0;
    int hi_n = 0, lo_n = 1000;
    logic prev_tv = 1'b0;
    logic [7:0] prev_d = '0;
    em_t obs[$];
    em_t exp_q[$];
    int obs_base = 0;
    int nq[$];
    int lq[$];
    bit fs = 1'b1;
    int last_rise = -1000;

    spi_byte_feeder_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) ifc ();
    spi_byte_feeder #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .VALID_HI(VH), .BYTE_GAP(BG)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_tv <= 1'b0;
            prev_d <= '0;
            hi_n <= 0;
            lo_n <= 1000;
        end else begin
            if (ifc.tx_valid && !prev_tv) begin
                obs.push_back('{cyc, ifc.tx_data});
                if (lo_n < BG) gap_bad <= gap_bad + 1;
                hi_n <= 1;
            end else if (ifc.tx_valid) begin
                hi_n <= hi_n + 1;
            end
            if (!ifc.tx_valid && prev_tv) begin
                if (hi_n != VH) wid_bad <= wid_bad + 1;
                lo_n <= 1;
            end else if (!ifc.tx_valid) begin
                lo_n <= lo_n + 1;
            end
            if (ifc.tx_data != prev_d && !(ifc.tx_valid && !prev_tv)) dat_bad <= dat_bad + 1;
            prev_tv <= ifc.tx_valid;
            prev_d <= ifc.tx_data;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    function automatic int mx(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic int mlevel(input int c);
        int n = 0;
        foreach (nq[i]) if (nq[i] < c) n++;
        foreach (lq[i]) if (lq[i] < c) n--;
        return n;
    endfunction

    function automatic bit mbusy(input int c);
        bit b = mlevel(c) > 0;
        foreach (exp_q[i]) if (exp_q[i].cyc - 1 <= c && c <= exp_q[i].cyc + VH + BG - 1) b = 1'b1;
        return b;
    endfunction

    task automatic mpush(input logic [7:0] d, input bit l);
        int h, r;
        if (HDR && fs) begin
            h = mx(cyc + 3, last_rise + PER);
            exp_q.push_back('{h, 8'hA5});
            last_rise = h;
            fs = 1'b0;
        end
        r = mx(cyc + 3, last_rise + PER);
        exp_q.push_back('{r, d});
        nq.push_back(cyc);
        lq.push_back(r - 1);
        last_rise = r;
        if (HDR && l) fs = 1'b1;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit l, output bit acc);
        int lv;
        @(negedge clk);
        lv = mlevel(cyc);
        chk("fifo_level", int'(ifc.fifo_level), lv);
        chk("in_ready", int'(ifc.in_ready), int'(lv < DEPTH));
        chk("busy", int'(ifc.busy), int'(mbusy(cyc)));
        acc = v && lv < DEPTH;
        ifc.in_valid = v;
        ifc.in_data = d;
        ifc.in_last = l;
        if (acc) mpush(d, l);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic drain();
        bit a;
        int i;
        for (i = 0; i < 3000 && mbusy(cyc + 1); i++) step(1'b0, 8'h00, 1'b0, a);
        chk("drain_timeout", int'(i >= 3000), 0);
        step(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic flush();
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        chk("emit_count", obs.size() - obs_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && obs_base + i < obs.size(); i++) begin
            chk("emit_data", int'(obs[obs_base + i].d), int'(exp_q[i].d));
            chk("emit_cycle", obs[obs_base + i].cyc, exp_q[i].cyc);
        end
        chk("pulse_width_errs", wid_bad, 0);
        chk("gap_len_errs", gap_bad, 0);
        chk("tx_data_change_errs", dat_bad, 0);
        obs_base = obs.size();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", int'(ifc.tx_valid), 0);
        chk("rst_tx_data", int'(ifc.tx_data), 0);
        chk("rst_in_ready", int'(ifc.in_ready), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_level", int'(ifc.fifo_level), 0);
        flush();
        ifc.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nq.delete();
        lq.delete();
        fs = 1'b1;
        last_rise = -1000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [7:0] seq5[$];
        bit acc;
        int n0, b, k0, target, tries, r55;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        ifc.in_last = 1'b0;
        tbl[0] = '{8'h3C, 1'b1, 2, HDR ? 8'hA5 : 8'h3C, HDR ? 2 : 1};
        tbl[1] = '{8'h00, 1'b1, 5, HDR ? 8'hA5 : 8'h00, HDR ? 2 : 1};
        tbl[2] = '{8'hFF, 1'b0, 1, HDR ? 8'hA5 : 8'hFF, HDR ? 2 : 1};
        tbl[3] = '{8'h80, 1'b1, 3, 8'h80, 1};
        tbl[4] = '{8'h7E, 1'b1, 0, HDR ? 8'hA5 : 8'h7E, HDR ? 2 : 1};
        if (HDR) seq5 = '{8'hA5, 8'h11, 8'h22, 8'hA5, 8'h33};
        else seq5 = '{8'h11, 8'h22, 8'h33};

        do_reset();
        idle(1);

        for (int i = 0; i < 5; i++) begin
            idle(tbl[i].idle);
            b = obs.size();
            step(1'b1, tbl[i].d, tbl[i].l, acc);
            n0 = cyc;
            chk("tbl_accept", int'(acc), 1);
            drain();
            chk("tbl_count", obs.size() - b, tbl[i].exp_n);
            if (obs.size() > b) begin
                chk("tbl_first_data", int'(obs[b].d), int'(tbl[i].exp_first));
                chk("tbl_latency", obs[b].cyc - n0, 3);
            end
            flush();
        end

        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, acc);
        drain();
        chk("b2b_count_min", int'(obs.size() - obs_base >= 4), 1);
        if (obs.size() - obs_base >= 4) begin
            for (int i = 0; i < 4; i++) chk("b2b_order", int'(obs[obs.size() - 4 + i].d), i + 1);
            for (int i = 1; i < 4; i++) chk("b2b_spacing", obs[obs.size() - 4 + i].cyc - obs[obs.size() - 5 + i].cyc, PER);
        end
        chk("b2b_busy_end", int'(ifc.busy), 0);
        flush();

        k0 = lq.size();
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, acc);
        target = lq[k0 + 1];
        while (cyc + 1 < target) step(1'b0, 8'h00, 1'b0, acc);
        chk("simul_level_before", int'(ifc.fifo_level), 5);
        step(1'b1, 8'h67, 1'b0, acc);
        chk("simul_accept", int'(acc), 1);
        step(1'b0, 8'h00, 1'b0, acc);
        chk("simul_level_after", int'(ifc.fifo_level), 5);
        drain();
        b = -1;
        for (int i = obs_base; i < obs.size(); i++) if (obs[i].cyc == target + 1) b = i;
        chk("simul_pop_found", int'(b >= 0), 1);
        if (b >= 0) chk("simul_pop_oldest", int'(obs[b].d), 8'h62);
        flush();

        step(1'b1, 8'h90, 1'b0, acc);
        target = exp_q[$].cyc + VH;
        while (cyc + 1 < target) step(1'b0, 8'h00, 1'b0, acc);
        k0 = lq.size();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'hB0 + i), 1'b0, acc);
            chk("stall_fill_accept", int'(acc), 1);
        end
        tries = 0;
        do begin
            step(1'b1, 8'hC0, 1'b0, acc);
            tries++;
            if (tries == 1) chk("stall_full_ready", int'(ifc.in_ready), 0);
        end while (!acc && tries < 200);
        chk("stall_refused", int'(tries > 1), 1);
        chk("stall_accept_cycle", cyc, lq[k0] + 1);
        drain();
        flush();

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 3) == 0, acc);
        drain();
        flush();

        do_reset();
        idle(1);
        step(1'b1, 8'h55, 1'b0, acc);
        r55 = exp_q[$].cyc;
        step(1'b1, 8'h66, 1'b0, acc);
        while (cyc < r55) step(1'b0, 8'h00, 1'b0, acc);
        chk("pulse_before_reset", int'(ifc.tx_valid), 1);
        chk("pulse_before_reset_data", int'(ifc.tx_data), 8'h55);
        do_reset();
        b = obs.size();
        idle(80);
        chk("no_pulse_after_reset", obs.size() - b, 0);
        flush();

        step(1'b1, 8'h11, 1'b0, acc);
        step(1'b1, 8'h22, 1'b1, acc);
        step(1'b1, 8'h33, 1'b1, acc);
        drain();
        chk("frame_seq_len", obs.size() - obs_base, seq5.size());
        for (int i = 0; i < seq5.size() && obs_base + i < obs.size(); i++)
            chk("frame_seq_data", int'(obs[obs_base + i].d), int'(seq5[i]));
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
